// File: rtl/alu_pkg.sv
// alu_pkg -- ALU operations, operand/result structs and divider constants. (rev 1.1)
`default_nettype none

package alu_pkg;

  localparam int DIV_CYCLES = 16;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLL = 4'd4,
    ALU_SRL = 4'd5,
    ALU_SRA = 4'd6,
    ALU_ROL = 4'd7,
    ALU_ROR = 4'd8,
    ALU_MUL = 4'd9,
    ALU_DIV = 4'd10
  } control_e;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } in_t;

  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] lo;
  } alu_result_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_e;

endpackage

`default_nettype wire

// File: rtl/types_pkg.sv
// types_pkg -- pipeline-wide shared types. (rev 1.0)
`default_nettype none

package types_pkg;

  typedef struct packed {
    logic rd;
    logic wr;
  } memc_t;

endpackage

`default_nettype wire

// File: rtl/alu_divider.sv
// alu_divider -- signed restoring divider, one quotient bit per cycle. (rev 1.0)
`default_nettype none

module alu_divider #(
  parameter int DIV_CYCLES = alu_pkg::DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_sys,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic        accept,
  output logic [15:0] quot,
  output logic [15:0] rem
);
  import alu_pkg::*;

  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);

  div_state_e    state, state_next;
  logic [CW-1:0] count;
  logic [15:0]   q_reg, r_reg, d_reg;
  logic          neg_q, neg_r;
  logic [15:0]   abs_a, abs_b, q_step, r_step;
  logic [16:0]   r_shift, r_diff;

  always_comb begin
    abs_a   = a[15] ? -a : a;
    abs_b   = b[15] ? -b : b;
    accept  = (state == IDLE) && start;
    done    = (state == RUN) && (count == LAST);
    busy    = accept || ((state == RUN) && (count != LAST));
    // The last iteration is evaluated combinationally so the result is ready in the final cycle.
    r_shift = {r_reg, q_reg[15]};
    r_diff  = r_shift - {1'b0, d_reg};
    if (!r_diff[16]) begin
      r_step = r_diff[15:0];
      q_step = {q_reg[14:0], 1'b1};
    end else begin
      r_step = r_shift[15:0];
      q_step = {q_reg[14:0], 1'b0};
    end
    quot = neg_q ? -q_step : q_step;
    rem  = neg_r ? -r_step : r_step;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      q_reg <= '0;
      r_reg <= '0;
      d_reg <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (!halt_sys) begin
      state <= state_next;
      if (accept) begin
        count <= '0;
        q_reg <= abs_a;
        r_reg <= '0;
        d_reg <= abs_b;
        neg_q <= a[15] ^ b[15];
        neg_r <= a[15];
      end else if (done) begin
        count <= '0;
      end else if (state == RUN) begin
        count <= count + CW'(1);
        q_reg <= q_step;
        r_reg <= r_step;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/stage_two.sv
// stage_two -- execute stage: operand forwarding, ALU, iterative DIV, stage-2/3 register. (rev 1.1)
`default_nettype none

module stage_two #(
  parameter int DIV_CYCLES = alu_pkg::DIV_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 halt_sys,
  input  types_pkg::memc_t     in_memc,
  input  logic                 in_reg_wr,
  input  alu_pkg::in_t         in_alu,
  input  logic                 in_haz1,
  input  logic                 in_haz2,
  input  logic                 in_R0_en,
  input  alu_pkg::control_e    in_alu_ctrl,
  input  logic [15:0]          in_instr,
  input  logic [15:0]          in_R1_data,
  input  logic [15:0]          s3_fwd_data,
  output logic [31:0]          aluout,
  output logic                 ex_busy,
  output logic [31:0]          out_alu,
  output types_pkg::memc_t     out_memc,
  output logic                 out_reg_wr,
  output logic                 out_R0_en,
  output logic [15:0]          out_instr,
  output logic [15:0]          out_R1_data,
  output logic                 out_div0,
  output logic                 out_overflow
);
  import alu_pkg::*;

  logic [15:0]        op_a, op_b, quot, rem;
  logic [3:0]         sh;
  logic signed [31:0] ext_a, ext_b, prod;
  alu_result_t        res;
  logic               ovf, div0, div_start, div_busy, div_done, div_accept;

  types_pkg::memc_t   lat_memc;
  logic               lat_reg_wr, lat_R0_en, lat_ovf;
  logic [15:0]        lat_instr, lat_R1_data;

  always_comb begin
    op_a      = in_haz1 ? s3_fwd_data : in_alu.a;
    op_b      = in_haz2 ? s3_fwd_data : in_alu.b;
    sh        = op_b[3:0];
    ext_a     = {{16{op_a[15]}}, op_a};
    ext_b     = {{16{op_b[15]}}, op_b};
    prod      = ext_a * ext_b;
    div_start = (in_alu_ctrl == ALU_DIV) && (op_b != 16'h0000);
    res       = '0;
    ovf       = 1'b0;
    div0      = 1'b0;
    // A finishing divide owns the result path regardless of what op is presented.
    if (div_done) begin
      res.hi = rem;
      res.lo = quot;
      ovf    = lat_ovf;
    end else begin
      case (in_alu_ctrl)
        ALU_ADD: begin
          res.lo = op_a + op_b;
          ovf    = (op_a[15] == op_b[15]) && (res.lo[15] != op_a[15]);
        end
        ALU_SUB: begin
          res.lo = op_a - op_b;
          ovf    = (op_a[15] != op_b[15]) && (res.lo[15] != op_a[15]);
        end
        ALU_AND: res.lo = op_a & op_b;
        ALU_OR:  res.lo = op_a | op_b;
        ALU_SLL: res.lo = op_a << sh;
        ALU_SRL: res.lo = op_a >> sh;
        ALU_SRA: res.lo = $signed(op_a) >>> sh;
        ALU_ROL: res.lo = (op_a << sh) | (op_a >> (5'd16 - {1'b0, sh}));
        ALU_ROR: res.lo = (op_a >> sh) | (op_a << (5'd16 - {1'b0, sh}));
        ALU_MUL: res = alu_result_t'(prod);
        ALU_DIV: div0 = (op_b == 16'h0000);
        default: res = '0;
      endcase
    end
    aluout  = res;
    ex_busy = div_busy;
  end

  alu_divider #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .halt_sys (halt_sys),
    .start    (div_start),
    .a        (op_a),
    .b        (op_b),
    .busy     (div_busy),
    .done     (div_done),
    .accept   (div_accept),
    .quot     (quot),
    .rem      (rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_alu      <= '0;
      out_memc     <= '0;
      out_reg_wr   <= 1'b0;
      out_R0_en    <= 1'b0;
      out_instr    <= '0;
      out_R1_data  <= '0;
      out_div0     <= 1'b0;
      out_overflow <= 1'b0;
      lat_memc     <= '0;
      lat_reg_wr   <= 1'b0;
      lat_R0_en    <= 1'b0;
      lat_instr    <= '0;
      lat_R1_data  <= '0;
      lat_ovf      <= 1'b0;
    end else if (!halt_sys) begin
      if (div_accept) begin
        lat_memc    <= in_memc;
        lat_reg_wr  <= in_reg_wr;
        lat_R0_en   <= in_R0_en;
        lat_instr   <= in_instr;
        lat_R1_data <= in_R1_data;
        lat_ovf     <= (op_a == 16'h8000) && (op_b == 16'hFFFF);
      end
      if (ex_busy) begin
        out_alu      <= '0;
        out_memc     <= '0;
        out_reg_wr   <= 1'b0;
        out_R0_en    <= 1'b0;
        out_instr    <= '0;
        out_R1_data  <= '0;
        out_div0     <= 1'b0;
        out_overflow <= 1'b0;
      end else if (div_done) begin
        out_alu      <= res;
        out_memc     <= lat_memc;
        out_reg_wr   <= lat_reg_wr;
        out_R0_en    <= lat_R0_en;
        out_instr    <= lat_instr;
        out_R1_data  <= lat_R1_data;
        out_div0     <= 1'b0;
        out_overflow <= ovf;
      end else begin
        out_alu      <= res;
        out_memc     <= in_memc;
        out_reg_wr   <= in_reg_wr & ~div0;
        out_R0_en    <= in_R0_en & ~div0;
        out_instr    <= in_instr;
        out_R1_data  <= in_R1_data;
        out_div0     <= div0;
        out_overflow <= ovf;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stage_two.sv
// tb_stage_two -- self-checking bench for the execute stage with a behavioural ALU model.
`default_nettype none

module tb_stage_two;
  import alu_pkg::*;

  logic              clk = 1'b0;
  logic              rst, halt_sys;
  types_pkg::memc_t  in_memc, out_memc;
  logic              in_reg_wr, in_haz1, in_haz2, in_R0_en;
  in_t               in_alu;
  control_e          in_alu_ctrl;
  logic [15:0]       in_instr, in_R1_data, s3_fwd_data;
  logic [31:0]       aluout, out_alu;
  logic              ex_busy, out_reg_wr, out_R0_en, out_div0, out_overflow;
  logic [15:0]       out_instr, out_R1_data;

  int checks = 0;
  int failures = 0;

  stage_two dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys), .in_memc(in_memc), .in_reg_wr(in_reg_wr),
    .in_alu(in_alu), .in_haz1(in_haz1), .in_haz2(in_haz2), .in_R0_en(in_R0_en),
    .in_alu_ctrl(in_alu_ctrl), .in_instr(in_instr), .in_R1_data(in_R1_data),
    .s3_fwd_data(s3_fwd_data), .aluout(aluout), .ex_busy(ex_busy), .out_alu(out_alu),
    .out_memc(out_memc), .out_reg_wr(out_reg_wr), .out_R0_en(out_R0_en),
    .out_instr(out_instr), .out_R1_data(out_R1_data), .out_div0(out_div0),
    .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout reached without summary");
    $fatal(1, "timeout");
  end

  // Reference arithmetic on signed integers; rotations done bit by bit.
  function automatic logic [31:0] model(input control_e op, input logic [15:0] a, input logic [15:0] b,
                                        output logic ovf, output logic dz);
    int sa, sb, r, q, m;
    int unsigned sh;
    logic [15:0] lo;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sh = int'(b[3:0]);
    ovf = 1'b0;
    dz = 1'b0;
    model = 32'h0;
    case (op)
      ALU_ADD: begin r = sa + sb; ovf = (r > 32767) || (r < -32768); model = {16'h0, r[15:0]}; end
      ALU_SUB: begin r = sa - sb; ovf = (r > 32767) || (r < -32768); model = {16'h0, r[15:0]}; end
      ALU_AND: model = {16'h0, a & b};
      ALU_OR:  model = {16'h0, a | b};
      ALU_SLL: begin lo = a << sh; model = {16'h0, lo}; end
      ALU_SRL: begin lo = a >> sh; model = {16'h0, lo}; end
      ALU_SRA: begin r = sa >>> sh; model = {16'h0, r[15:0]}; end
      ALU_ROL: begin lo = a; repeat (sh) lo = {lo[14:0], lo[15]}; model = {16'h0, lo}; end
      ALU_ROR: begin lo = a; repeat (sh) lo = {lo[0], lo[15:1]}; model = {16'h0, lo}; end
      ALU_MUL: begin r = sa * sb; model = r; end
      ALU_DIV: begin
        if (sb == 0) dz = 1'b1;
        else begin
          q = sa / sb;
          m = sa % sb;
          ovf = (sa == -32768) && (sb == -1);
          model = {m[15:0], q[15:0]};
        end
      end
      default: model = 32'h0;
    endcase
  endfunction

  task automatic set_in(input control_e op, input logic [15:0] a, input logic [15:0] b,
                        input logic h1, input logic h2, input logic [15:0] fwd,
                        input logic rw, input logic r0, input logic [15:0] instr,
                        input logic [15:0] r1, input logic [1:0] mc);
    in_alu_ctrl = op;
    in_alu.a = a;
    in_alu.b = b;
    in_haz1 = h1;
    in_haz2 = h2;
    s3_fwd_data = fwd;
    in_reg_wr = rw;
    in_R0_en = r0;
    in_instr = instr;
    in_R1_data = r1;
    in_memc = types_pkg::memc_t'(mc);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    halt_sys = 1'b0;
    set_in(ALU_ADD, 16'h0, 16'h0, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 2'b00);
    repeat (2) tick();
    checks++;
    if ({out_alu, out_memc, out_reg_wr, out_R0_en, out_instr, out_R1_data, out_div0, out_overflow} !== '0)
      begin failures++; $display("FAIL reset_outputs got alu=%h instr=%h exp all zero", out_alu, out_instr); end
    checks++;
    if (ex_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", ex_busy); end
    rst = 1'b0;
  endtask

  task automatic test_add_overflow();
    set_in(ALU_ADD, 16'h7FFF, 16'h0001, 0, 0, 16'h0, 1, 0, 16'h1111, 16'h2222, 2'b01);
    tick();
    checks++;
    if (out_alu !== 32'h0000_8000) begin failures++; $display("FAIL add_alu got=%h exp=00008000", out_alu); end
    checks++;
    if (out_overflow !== 1'b1) begin failures++; $display("FAIL add_ovf got=%b exp=1", out_overflow); end
    checks++;
    if (out_reg_wr !== 1'b1 || out_instr !== 16'h1111 || out_R1_data !== 16'h2222 || out_memc !== 2'b01)
      begin failures++; $display("FAIL add_pass got rw=%b instr=%h exp rw=1 instr=1111", out_reg_wr, out_instr); end
  endtask

  task automatic test_mul();
    set_in(ALU_MUL, 16'hFFFE, 16'h0003, 0, 0, 16'h0, 1, 1, 16'h3333, 16'h0, 2'b00);
    tick();
    checks++;
    if (out_alu !== 32'hFFFF_FFFA) begin failures++; $display("FAIL mul_alu got=%h exp=FFFFFFFA", out_alu); end
    checks++;
    if (out_R0_en !== 1'b1 || out_overflow !== 1'b0)
      begin failures++; $display("FAIL mul_flags got r0=%b ovf=%b exp r0=1 ovf=0", out_R0_en, out_overflow); end
  endtask

  task automatic test_div_forward();
    int busy_cnt, bad;
    busy_cnt = 0;
    bad = 0;
    set_in(ALU_DIV, 16'h1234, 16'h0002, 1, 0, 16'hFFF9, 1, 1, 16'hD00D, 16'hBEEF, 2'b10);
    #1;
    checks++;
    if (ex_busy !== 1'b1) begin failures++; $display("FAIL divf_busy_start got=%b exp=1", ex_busy); end
    while (ex_busy === 1'b1 && busy_cnt < 40) begin
      tick();
      busy_cnt++;
      s3_fwd_data = 16'($urandom);
      #1;
      if (out_reg_wr !== 0 || out_R0_en !== 0 || out_instr !== 0 || out_memc !== 0 || out_div0 !== 0 || out_overflow !== 0)
        bad++;
    end
    checks++;
    if (busy_cnt != 16) begin failures++; $display("FAIL divf_busy_cycles got=%0d exp=16", busy_cnt); end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL divf_bubbles got=%0d bad bubbles exp=0", bad); end
    checks++;
    if (aluout !== 32'hFFFF_FFFD) begin failures++; $display("FAIL divf_aluout got=%h exp=FFFFFFFD", aluout); end
    tick();
    checks++;
    if (out_alu !== 32'hFFFF_FFFD) begin failures++; $display("FAIL divf_alu got=%h exp=FFFFFFFD", out_alu); end
    checks++;
    if (out_reg_wr !== 1 || out_R0_en !== 1 || out_instr !== 16'hD00D || out_R1_data !== 16'hBEEF || out_memc !== 2'b10)
      begin failures++; $display("FAIL divf_pass got rw=%b r0=%b instr=%h exp 1 1 D00D", out_reg_wr, out_R0_en, out_instr); end
    set_in(ALU_ADD, 16'h0, 16'h0, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 2'b00);
  endtask

  task automatic test_div_zero();
    set_in(ALU_DIV, 16'h0005, 16'h0000, 0, 0, 16'h0, 1, 1, 16'h4444, 16'h0, 2'b00);
    #1;
    checks++;
    if (ex_busy !== 1'b0) begin failures++; $display("FAIL div0_busy got=%b exp=0", ex_busy); end
    tick();
    checks++;
    if (out_alu !== 32'h0 || out_div0 !== 1'b1)
      begin failures++; $display("FAIL div0_result got alu=%h div0=%b exp 0 1", out_alu, out_div0); end
    checks++;
    if (out_reg_wr !== 1'b0 || out_R0_en !== 1'b0 || out_instr !== 16'h4444)
      begin failures++; $display("FAIL div0_ctrl got rw=%b r0=%b instr=%h exp 0 0 4444", out_reg_wr, out_R0_en, out_instr); end
  endtask

  task automatic test_halt_timing();
    int rest;
    rest = 0;
    set_in(ALU_DIV, 16'd100, 16'd7, 0, 0, 16'h0, 1, 0, 16'h5555, 16'h0, 2'b00);
    repeat (5) tick();
    halt_sys = 1'b1;
    repeat (3) tick();
    checks++;
    if (ex_busy !== 1'b1 || out_instr !== 16'h0)
      begin failures++; $display("FAIL halt_hold got busy=%b instr=%h exp 1 0000", ex_busy, out_instr); end
    halt_sys = 1'b0;
    #1;
    while (ex_busy === 1'b1 && rest < 40) begin tick(); rest++; end
    checks++;
    if (rest != 11) begin failures++; $display("FAIL halt_remaining got=%0d exp=11", rest); end
    tick();
    checks++;
    if (out_alu !== 32'h0002_000E || out_instr !== 16'h5555)
      begin failures++; $display("FAIL halt_result got=%h exp=0002000E", out_alu); end
    set_in(ALU_ADD, 16'h0, 16'h0, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 2'b00);
  endtask

  task automatic test_halt_rst();
    int bad;
    logic o, z;
    logic [31:0] exp;
    bad = 0;
    set_in(ALU_DIV, 16'd100, 16'd7, 0, 0, 16'h0, 1, 1, 16'h6666, 16'h7777, 2'b11);
    repeat (8) tick();
    halt_sys = 1'b1;
    repeat (5) tick();
    checks++;
    if (ex_busy !== 1'b1) begin failures++; $display("FAIL hrst_busy_in_halt got=%b exp=1", ex_busy); end
    halt_sys = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({out_alu, out_memc, out_reg_wr, out_R0_en, out_instr, out_R1_data, out_div0, out_overflow} !== '0)
      begin failures++; $display("FAIL hrst_outputs got alu=%h instr=%h exp all zero", out_alu, out_instr); end
    rst = 1'b0;
    set_in(ALU_AND, 16'h0F0F, 16'h00FF, 0, 0, 16'h0, 1, 0, 16'h0ABC, 16'h0, 2'b00);
    exp = model(ALU_AND, 16'h0F0F, 16'h00FF, o, z);
    #1;
    checks++;
    if (ex_busy !== 1'b0) begin failures++; $display("FAIL hrst_busy_after got=%b exp=0", ex_busy); end
    repeat (20) begin
      tick();
      if (out_alu !== exp || out_instr !== 16'h0ABC || out_R0_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL hrst_no_completion got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    set_in(ALU_DIV, 16'd100, 16'd7, 0, 0, 16'h0, 1, 0, 16'h0100, 16'h0, 2'b00);
    #1;
    while (ex_busy === 1'b1 && n < 40) begin tick(); n++; end
    tick();
    checks++;
    if (out_alu !== 32'h0002_000E) begin failures++; $display("FAIL b2b_div got=%h exp=0002000E", out_alu); end
    set_in(ALU_ADD, 16'd1, 16'd1, 0, 0, 16'h0, 1, 0, 16'h0200, 16'h0, 2'b00);
    tick();
    checks++;
    if (out_alu !== 32'h0000_0002 || out_instr !== 16'h0200)
      begin failures++; $display("FAIL b2b_add got=%h exp=00000002", out_alu); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      control_e op;
      logic [15:0] a, b, fwd, ea, eb, instr;
      logic h1, h2, rw, r0, eo, ez;
      logic [31:0] exp;
      int n, exp_n, bad;
      op = control_e'(4'($urandom_range(0, 10)));
      a = 16'($urandom);
      b = 16'($urandom);
      fwd = 16'($urandom);
      h1 = 1'($urandom);
      h2 = 1'($urandom);
      rw = 1'($urandom);
      r0 = 1'($urandom);
      instr = 16'($urandom);
      if (op == ALU_DIV && $urandom_range(0, 4) == 0) begin h2 = 0; b = 16'h0; end
      if (op == ALU_DIV && $urandom_range(0, 5) == 0) begin h1 = 0; h2 = 0; a = 16'h8000; b = 16'hFFFF; end
      ea = h1 ? fwd : a;
      eb = h2 ? fwd : b;
      exp = model(op, ea, eb, eo, ez);
      exp_n = (op == ALU_DIV && eb != 16'h0) ? 16 : 0;
      set_in(op, a, b, h1, h2, fwd, rw, r0, instr, 16'(it), 2'(it));
      #1;
      n = 0;
      bad = 0;
      while (ex_busy === 1'b1 && n < 40) begin
        tick();
        n++;
        s3_fwd_data = 16'($urandom);
        #1;
        if (out_reg_wr !== 0 || out_R0_en !== 0 || out_instr !== 0 || out_overflow !== 0) bad++;
      end
      checks++;
      if (n != exp_n || bad != 0)
        begin failures++; $display("FAIL rnd_latency it=%0d op=%0d got=%0d bad=%0d exp=%0d", it, op, n, bad, exp_n); end
      tick();
      checks++;
      if (out_alu !== exp)
        begin failures++; $display("FAIL rnd_alu it=%0d op=%0d a=%h b=%h got=%h exp=%h", it, op, ea, eb, out_alu, exp); end
      checks++;
      if (out_overflow !== eo || out_div0 !== ez)
        begin failures++; $display("FAIL rnd_flags it=%0d got ovf=%b dz=%b exp ovf=%b dz=%b", it, out_overflow, out_div0, eo, ez); end
      checks++;
      if (out_reg_wr !== (rw & ~ez) || out_R0_en !== (r0 & ~ez) || out_instr !== instr || out_R1_data !== 16'(it))
        begin failures++; $display("FAIL rnd_pass it=%0d got rw=%b r0=%b instr=%h exp rw=%b r0=%b instr=%h",
                                    it, out_reg_wr, out_R0_en, out_instr, rw & ~ez, r0 & ~ez, instr); end
      set_in(ALU_AND, 16'h0, 16'h0, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 2'b00);
    end
  endtask

  initial begin
    set_in(ALU_ADD, 16'h0, 16'h0, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 2'b00);
    rst = 1'b1;
    halt_sys = 1'b0;
    @(negedge clk);
    test_reset();
    test_add_overflow();
    test_mul();
    test_div_forward();
    test_div_zero();
    test_halt_timing();
    test_halt_rst();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stage_two.md
# stage_two

Execute stage of the three-stage pipeline. Sits between `stage_one` (decode/register-read) and stage three (memory/writeback). It consumes `stage_one`'s flopped outputs, resolves operand forwarding from stage three, and computes the 32-bit ALU result: single-cycle for most ops, 16-iteration sequential for DIV. It registers the result and control into the stage-two/three pipeline register, and drives `aluout` combinationally back to `stage_one` for comparator and hazard forwarding.

## Interface
Parameters:
- `DIV_CYCLES`, default 16: divider iterations; equals operand width.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` in 1: system clock, rising edge.
  - `rst` in 1: synchronous active-high reset.
- Inputs from `stage_one` and the system:
  - `halt_sys` in 1: freeze all state, including divider and pipeline register.
  - `in_memc` in `types_pkg::memc_t`: memory control from `stage_one`.
  - `in_reg_wr` in 1: register write enable.
  - `in_alu` in `alu_pkg::in_t`: operands a and b, 16 bits each.
  - `in_haz1` in 1: replace operand a with `s3_fwd_data`.
  - `in_haz2` in 1: replace operand b with `s3_fwd_data`.
  - `in_R0_en` in 1: upper result half is to be written to R0.
  - `in_alu_ctrl` in `alu_pkg::control_e`: operation.
  - `in_instr` in 16: instruction word.
  - `in_R1_data` in 16: store data.
  - `s3_fwd_data` in 16: stage-three writeback value.
- Outputs:
  - `aluout` out 32: combinational result of the current op; `{hi, lo}`.
  - `ex_busy` out 1: combinational stall request to `stage_one`.
  - `out_alu` out 32: registered result.
  - `out_memc`, `out_reg_wr`, `out_R0_en`, `out_instr`, `out_R1_data` out: registered pass-through.
  - `out_div0` out 1: registered divide-by-zero flag.
  - `out_overflow` out 1: registered signed overflow flag.

## Operation
Operand selection:
- a = `in_haz1` ? `s3_fwd_data` : `in_alu.a`.
- b = `in_haz2` ? `s3_fwd_data` : `in_alu.b`.

Results, all signed 16-bit unless noted:
- ADD/SUB: lo = a±b mod 2^16, hi = 0; overflow on signed overflow.
- AND/OR: bitwise, hi = 0.
- SLL/SRL/SRA/ROL/ROR: shift a by b[3:0], hi = 0.
- MUL: {hi, lo} = signed 32-bit product a*b. Never flags overflow.
- DIV: lo = quotient truncated toward zero; hi = remainder, sign of dividend.
  - -32768/-1 gives quotient -32768, remainder 0, overflow = 1.
  - b == 0: no iteration; result 0, div0 = 1, `out_reg_wr` and `out_R0_en` forced to 0.

Divider FSM (in `alu_divider`):
- IDLE: if op is DIV and b != 0, latch |a|, |b|, signs and all pass-through inputs; go to RUN; count = 0.
- RUN: one restoring shift-subtract per cycle; count increments.
  - At count == `DIV_CYCLES`-1 the sign-corrected result is valid on `aluout`; return to IDLE at that edge.
- `ex_busy` = (IDLE & DIV & b != 0) | (RUN & count != `DIV_CYCLES`-1).

Pipeline register:
- Loads every non-halted edge.
- While `ex_busy`, it loads a bubble: reg_wr = 0, R0_en = 0, memc = 0, instr = 0, flags = 0.
- DIV completion loads the latched pass-through copies, not the live inputs.

## Timing
- Reset values: every output register is 0, FSM is IDLE, count is 0, `ex_busy` is 0.
- Non-DIV ops: latency 1. Presented in cycle N, result on `out_alu` after edge N.
- DIV: presented in cycle N, result registered at edge N+`DIV_CYCLES`.
  - `ex_busy` is high in cycles N..N+`DIV_CYCLES`-1.
  - Bubbles fill edges N..N+`DIV_CYCLES`-1.
- `stage_one` holds its flop while `ex_busy` is high. In the completion cycle `ex_busy` is 0, so `stage_one` advances at the same edge the result is registered.
- `s3_fwd_data` is sampled only when an op is accepted. Later changes do not affect an in-flight divide.
- `halt_sys` takes priority over everything except `rst`: FSM, count and output registers hold. `ex_busy` still evaluates from the held state.
- `rst` mid-divide: the next edge aborts to IDLE with zeroed outputs, and no partial result escapes.
- Divide-by-zero: single cycle, `ex_busy` stays 0.

## Structure
- `alu_pkg` gains:
  - `div_state_e` {IDLE, RUN}.
  - `DIV_CYCLES` constant.
  - `alu_result_t` struct {hi, lo}.
- `types_pkg` is unchanged.
- Sub-module `alu_divider`: signed iterative divider.
  - Inputs: `clk`, `rst`, `halt_sys`, `start`, `a`, `b`.
  - Outputs: `busy`, `done`, `quot`, `rem`.
- Single-cycle datapath and pipeline register live in `stage_two`.

## Test plan
- Reset, then ADD a=0x7FFF b=0x0001 -> after 1 edge `out_alu`=0x0000_8000, `out_overflow`=1, `out_reg_wr` passed through.
- MUL a=0xFFFE (-2), b=0x0003, `in_R0_en`=1 -> `out_alu`=0xFFFF_FFFA, `out_R0_en`=1, latency 1.
- DIV a=-7, b=2 with `in_haz1`=1, `s3_fwd_data`=-7, then `s3_fwd_data` changed mid-run -> `ex_busy` high exactly 16 cycles, 16 bubbles, then `out_alu`=0xFFFF_FFFD (rem -1, quot -3).
- DIV a=5, b=0 -> same-cycle result, `out_alu`=0, `out_div0`=1, `out_reg_wr`=0, `ex_busy` never asserted.
- DIV started, `halt_sys` high for 5 cycles at count 7, then `rst` at count 10 -> count frozen during halt; after `rst`, IDLE with all outputs 0 and no completion.
- Back-to-back DIV 100/7 then ADD 1+1 -> `out_alu` 0x0002_000E, then 0x0000_0002 on the next edge.
